// File: rtl/aes256_key_expand.sv
// ---------------------------------------------------------------------------
// aes256_key_expand
//
// AES-256 key schedule engine. It takes the 256-bit key from the byte-serial
// loader and expands it into 60 words (15 round keys), one word per cycle,
// from an 8-word sliding window. The words are held in flop storage. The
// cipher core reads them through a registered random-access port.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   key_in     in   256  key, w0 = key_in[255:224] .. w7 = key_in[31:0]
//   key_valid  in   1    level from loader; a 0->1 edge starts expansion
//   rk_idx     in   4    round key to read (0..14, 15 reads as zero)
//   rk_out     out  128  registered round key {w[4r],..,w[4r+3]}
//   busy       out  1    expansion in progress
//   done       out  1    all 60 words valid, held until next start/reset
//
// Build option:
//   KEYEXP_ZEROIZE_EN  when defined, the load edge also clears words 8..59,
//                      so a restart never exposes the previous key's
//                      round keys.
// ---------------------------------------------------------------------------

// Arithmetic AES S-box: GF(2^8) inverse computed as x^254, then the affine
// transform. Zero maps to zero through the exponentiation, which gives 0x63.
module aes256_key_expand_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain for x^254: 2,3,6,12,15,30,60,120,240,252,254.
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes256_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state_q, state_d;
  logic         kv_q, kv_d;
  logic [5:0]   idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic [31:0]  win_q [8];
  logic [31:0]  win_d [8];
  logic [31:0]  store_q [60];
  logic [31:0]  store_d [60];

  logic         start;
  logic [31:0]  sub_in, sub_out, temp, w_new;
  logic [7:0]   rcon;

  // An edge arriving during EXPAND is dropped because kv_q still follows it.
  assign start = key_valid & ~kv_q & (state_q != EXPAND);

  // RotWord is applied only at word indices that are multiples of 8.
  assign sub_in = (idx_q[2:0] == 3'd0) ? {win_q[7][23:0], win_q[7][31:24]} : win_q[7];

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes256_key_expand_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  // Rcon is indexed by i/8, which is 1..7 during expansion.
  always_comb begin
    case (idx_q[5:3])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    kv_d    = key_valid;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    win_d   = win_q;
    store_d = store_q;

    if (idx_q[2:0] == 3'd0)      temp = sub_out ^ {rcon, 24'h000000};
    else if (idx_q[2:0] == 3'd4) temp = sub_out;
    else                         temp = win_q[7];
    w_new = win_q[0] ^ temp;

    if (start) begin
      for (int k = 0; k < 8; k++) begin
        win_d[k]   = key_in[255-32*k -: 32];
        store_d[k] = key_in[255-32*k -: 32];
      end
`ifdef KEYEXP_ZEROIZE_EN
      for (int k = 8; k < 60; k++) store_d[k] = 32'h0;
`endif
      idx_d   = 6'd8;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      state_d = EXPAND;
    end else if (state_q == EXPAND) begin
      for (int k = 8; k < 60; k++) begin
        if (idx_q == 6'(k)) store_d[k] = w_new;
      end
      // win[0] always holds w[i-8] and win[7] holds w[i-1].
      for (int k = 0; k < 7; k++) win_d[k] = win_q[k+1];
      win_d[7] = w_new;
      idx_d    = idx_q + 6'd1;
      if (idx_q == 6'd59) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    // The read port returns whatever storage holds, even mid-expansion.
    rk_out_d = '0;
    for (int r = 0; r < 15; r++) begin
      if (rk_idx == 4'(r))
        rk_out_d = {store_q[4*r], store_q[4*r+1], store_q[4*r+2], store_q[4*r+3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kv_q     <= 1'b0;
      idx_q    <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rk_out_q <= '0;
      for (int k = 0; k < 8; k++)  win_q[k]   <= 32'h0;
      for (int k = 0; k < 60; k++) store_q[k] <= 32'h0;
    end else begin
      state_q  <= state_d;
      kv_q     <= kv_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rk_out_q <= rk_out_d;
      win_q    <= win_d;
      store_q  <= store_d;
    end
  end

  assign rk_out = rk_out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_aes256_key_expand.sv
// ---------------------------------------------------------------------------
// tb_aes256_key_expand
//
// Directed testbench for aes256_key_expand using FIPS-197 A.3 and all-zero
// key vectors. It covers start latency, the read port, level hold, restart,
// edges during expansion, reset mid-expansion and the zeroize option
// (KEYEXP_ZEROIZE_EN).
// ---------------------------------------------------------------------------
module tb_aes256_key_expand;

  localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_ZERO = 256'h0;
  localparam logic [127:0] A3_RK0   = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_RK1   = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3_RK2   = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_RK14  = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] Z_RK2    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK3    = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key_in;
  logic         key_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         busy;
  logic         done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes256_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic kv, input logic [255:0] key, input logic [3:0] idx);
    key_valid = kv;
    key_in    = key;
    rk_idx    = idx;
    stepEdge();
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitDone(input string tag, input int start_cnt);
    int cnt;
    cnt = start_cnt;
    while (done !== 1'b1 && cnt < 120) begin
      stepEdge();
      cnt++;
    end
    checkOutput(tag, 128'(cnt), 128'd52);
  endtask

  task automatic readKey(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    applyStimulus(key_valid, key_in, idx);
    checkOutput(tag, rk_out, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_idx    = 4'd0;
    #3;
    checkOutput("reset_rk_out", rk_out, 128'h0);
    checkOutput("reset_busy", 128'(busy), 128'h0);
    checkOutput("reset_done", 128'(done), 128'h0);
    stepEdge();
    stepEdge();
    rst_n = 1'b1;

    $display("[TB] all-zero key expansion");
    applyStimulus(1'b1, KEY_ZERO, 4'd0);
    checkOutput("zero_start_busy", 128'(busy), 128'h1);
    checkOutput("zero_start_done", 128'(done), 128'h0);
    waitDone("zero_latency", 0);
    checkOutput("zero_done_busy", 128'(busy), 128'h0);
    readKey("zero_rk0", 4'd0, 128'h0);
    readKey("zero_rk1", 4'd1, 128'h0);
    readKey("zero_rk2", 4'd2, Z_RK2);
    readKey("zero_rk3", 4'd3, Z_RK3);
    readKey("zero_rk15", 4'd15, 128'h0);

    $display("[TB] level hold after done");
    for (int k = 0; k < 4; k++) begin
      stepEdge();
      checkOutput("hold_busy", 128'(busy), 128'h0);
    end
    checkOutput("hold_done", 128'(done), 128'h1);

    $display("[TB] restart with A.3 key, edges during expansion ignored");
    applyStimulus(1'b0, KEY_A3, 4'd0);
    applyStimulus(1'b1, KEY_A3, 4'd0);
    checkOutput("restart_done_drop", 128'(done), 128'h0);
    checkOutput("restart_busy", 128'(busy), 128'h1);
    for (int k = 0; k < 9; k++) stepEdge();
    applyStimulus(1'b0, ~KEY_A3, 4'd0);
    applyStimulus(1'b1, ~KEY_A3, 4'd0);
    applyStimulus(1'b0, ~KEY_A3, 4'd0);
    applyStimulus(1'b1, ~KEY_A3, 4'd0);
    checkOutput("mid_edge_busy", 128'(busy), 128'h1);
    waitDone("a3_latency", 13);
    readKey("a3_rk0", 4'd0, A3_RK0);
    readKey("a3_rk1", 4'd1, A3_RK1);
    readKey("a3_rk2", 4'd2, A3_RK2);
    readKey("a3_rk14", 4'd14, A3_RK14);
    stepEdge();
    stepEdge();
    checkOutput("a3_hold_busy", 128'(busy), 128'h0);

    $display("[TB] restart read of stale round key 14");
    applyStimulus(1'b0, KEY_A3, 4'd14);
    applyStimulus(1'b1, KEY_A3, 4'd14);
    for (int k = 0; k < 5; k++) stepEdge();
`ifdef KEYEXP_ZEROIZE_EN
    checkOutput("zeroize_rk14", rk_out, 128'h0);
`else
    checkOutput("stale_rk14", rk_out, A3_RK14);
`endif
    waitDone("restart_latency", 5);
    checkOutput("restart_final_rk14", rk_out, A3_RK14);

    $display("[TB] reset during expansion");
    applyStimulus(1'b0, KEY_A3, 4'd0);
    applyStimulus(1'b1, KEY_A3, 4'd0);
    for (int k = 0; k < 19; k++) stepEdge();
    checkOutput("pre_reset_rk0", rk_out, A3_RK0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rk_out", rk_out, 128'h0);
    checkOutput("midrst_busy", 128'(busy), 128'h0);
    checkOutput("midrst_done", 128'(done), 128'h0);
    stepEdge();
    rst_n = 1'b1;
    stepEdge();
    checkOutput("post_reset_rk0", rk_out, 128'h0);
    checkOutput("post_reset_busy", 128'(busy), 128'h1);
    waitDone("post_reset_latency", 0);
    readKey("post_reset_rk14", 4'd14, A3_RK14);
    readKey("post_reset_rk1", 4'd1, A3_RK1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
